adc128s022_spi_master: RTL and testbench
========================================

# adc128s022_spi_master

SPI master for the DE0-Nano on-board ADC128S022 (8-channel, 12-bit). Runs continuous conversion frames while enabled and presents each result as a 12-bit word with a channel tag and a one-cycle valid strobe. The 12-bit sample output drives the `in_port` of the NIOS II ADC-data PIO, so it is the producer side of that interface. The block is fully synchronous to the system clock and generates SCLK from it with a divider.

## Interface
Parameters:
- `HALF_PERIOD`, default 16: clk cycles per SCLK half-period (H). At 50 MHz, SCLK is 1.5625 MHz. Legal range is 2..255; elaboration fails outside it.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: level; run conversions back-to-back while high.
- `channel`, in, 3: channel requested for the next conversion.
- `adc_cs_n`, out, 1: ADC chip select.
- `adc_sclk`, out, 1: ADC serial clock; idles high.
- `adc_din`, out, 1: address bits to the ADC.
- `adc_dout`, in, 1: serial data from the ADC.
- `data`, out, 12: last conversion result; connects to the PIO `in_port`.
- `data_channel`, out, 3: channel that `data` was converted from.
- `data_valid`, out, 1: one-cycle pulse when `data` and `data_channel` update.
- `busy`, out, 1: high while not in IDLE.

## Operation
- States:
  - IDLE: `cs_n`=1, `sclk`=1.
  - FRAME: `cs_n`=0, 16 SCLK cycles.
  - GAP: `cs_n`=1 for 2H.
- IDLE → FRAME when `enable`=1. At that transition, latch `channel` into `cur_ch`.
- FRAME → GAP after the last rising edge plus H.
- GAP → FRAME if `enable`=1 (re-latch `channel`); otherwise GAP → IDLE.
- Bit k (k = 0..15) within a frame:
  - On SCLK falling edge k, drive `adc_din`: bits 2, 3, 4 carry `cur_ch[2]`, `[1]`, `[0]`; all other bits are 0.
  - On rising edge k, shift `adc_dout` into a 16-bit shift register, MSB first.
- At FRAME exit:
  - `data` ← shift[11:0]. The 4 leading zeros are discarded and not checked.
  - `data_channel` ← `prev_ch`, then `prev_ch` ← `cur_ch`. The ADC converts the channel addressed in the previous frame. `prev_ch` resets to 0, which is the ADC power-on default.
  - `data_valid` pulses for 1 cycle.
- Boundary conditions:
  - `enable` falling mid-frame: the frame completes and produces a valid result, then the block goes to IDLE.
  - `channel` changes mid-frame: ignored until the next frame start.
  - `reset` mid-frame: all outputs return to reset values immediately. No valid pulse. The partial frame is abandoned; `cs_n` rising aborts it at the ADC.
- `adc_dout` is sampled on the clk edge that raises SCLK. The ADC changed it H cycles earlier, so no synchronizer is used.

## Timing
- Reset values:
  - `adc_cs_n`=1, `adc_sclk`=1, `adc_din`=0.
  - `data`=0, `data_channel`=0, `data_valid`=0, `busy`=0.
  - `prev_ch`=0.
- t0 is the cycle in which `cs_n` falls, which is 1 cycle after `enable` is sampled high in IDLE.
- Within a frame:
  - SCLK falling edge k at t0+(2k+1)H.
  - SCLK rising edge k at t0+(2k+2)H.
  - `cs_n` rises and `data_valid` pulses at t0+33H.
- Back-to-back frame period is 35H cycles: 560 clk at the default H.
- Output changes:
  - `adc_din` changes only in falling-edge cycles.
  - `adc_sclk`, `adc_cs_n` and `adc_din` are driven directly from flops.
- `busy` rises with `cs_n` falling. It drops in the cycle that GAP → IDLE.

## Structure
- Package `adc128s022_pkg` holds:
  - the state enum;
  - `FRAME_BITS` = 16;
  - `ADDR_MSB_BIT` = 2 and `ADDR_LSB_BIT` = 4;
  - `DATA_W` = 12;
  - `CH_W` = 3.
- Sub-module `adc_sclk_tick`: a half-period counter emitting a 1-cycle `tick` every H cycles while enabled. It is held cleared in IDLE.
- The main FSM owns the bit counter, SCLK toggle, shift register and output registers.

## Test plan
- Reset, then hold `enable`=0 for 100 cycles → all outputs at reset values, no SCLK activity.
- `enable`=1, `channel`=5, ADC model returns 0xA5C:
  - `adc_din` reads 1, 0, 1 at bits 2..4 and 0 elsewhere;
  - at t0+528: `data`=0xA5C, `data_channel`=0, with a single-cycle `data_valid`.
- Continuous operation with `channel`=5:
  - second frame `data_channel`=5;
  - `cs_n` falls exactly 560 cycles after the first falling edge.
- Drop `enable` at bit 7:
  - frame completes with a valid pulse;
  - block returns to IDLE after 2H; `busy`=0; no further `cs_n` activity.
- Assert `reset` at bit 10 → same cycle: `cs_n`=1, `sclk`=1; no `data_valid`; the next frame after release starts cleanly.
- `HALF_PERIOD`=2, with `channel` toggled mid-frame → edge timing still matches the formulas; `adc_din` uses the channel latched at frame start.

Source files
------------

// File: rtl/adc128s022_pkg.sv
// Shared types and frame constants for the ADC128S022 SPI master.
package adc128s022_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int FRAME_BITS   = 16;
  localparam int ADDR_MSB_BIT = 2;
  localparam int ADDR_LSB_BIT = 4;
  localparam int DATA_W       = 12;
  localparam int CH_W         = 3;

  // Half-period ticks counted from cs_n falling: 32 SCLK edges, then one
  // more half period before cs_n rises, then two half periods of gap.
  localparam int HALF_EXIT = 2 * FRAME_BITS + 1;
  localparam int HALF_END  = 2 * FRAME_BITS + 3;

  // DIN value for frame bit k: the channel address sits MSB first in bits 2..4.
  function automatic logic addr_bit(input logic [3:0] k, input logic [CH_W-1:0] ch);
    if (k == 4'(ADDR_MSB_BIT))          return ch[2];
    else if (k == 4'(ADDR_MSB_BIT + 1)) return ch[1];
    else if (k == 4'(ADDR_LSB_BIT))     return ch[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/adc_sclk_tick.sv
// Half-period timebase: one-cycle tick every HALF_PERIOD clocks while running.
module adc_sclk_tick #(
  parameter int HALF_PERIOD = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_tick
);

  logic [7:0] r_cnt;
  logic       w_last;

  assign w_last = (r_cnt == 8'(HALF_PERIOD - 1));
  assign o_tick = i_run && w_last;

  // Count clocks within a half period; held at zero while not running so the
  // first tick of a frame lands exactly HALF_PERIOD cycles after start.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      r_cnt <= '0;
    else if (!i_run)  r_cnt <= '0;
    else if (w_last)  r_cnt <= '0;
    else              r_cnt <= r_cnt + 8'd1;
  end

endmodule

// File: rtl/adc128s022_spi_master.sv
// Continuous-conversion SPI master for the ADC128S022 on the DE0-Nano.
module adc128s022_spi_master
  import adc128s022_pkg::*;
#(
  parameter int HALF_PERIOD = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [CH_W-1:0]   i_channel,
  output logic              o_adc_cs_n,
  output logic              o_adc_sclk,
  output logic              o_adc_din,
  input  logic              i_adc_dout,
  output logic [DATA_W-1:0] o_data,
  output logic [CH_W-1:0]   o_data_channel,
  output logic              o_data_valid,
  output logic              o_busy
);

  if (HALF_PERIOD < 2 || HALF_PERIOD > 255) begin : g_bad_half_period
    $error("adc128s022_spi_master: HALF_PERIOD must be within 2..255");
  end

  state_t            r_state;
  logic [5:0]        r_half;
  logic [DATA_W-1:0] r_shift;
  logic [CH_W-1:0]   r_cur_ch;
  logic [CH_W-1:0]   r_prev_ch;
  logic              r_cs_n;
  logic              r_sclk;
  logic              r_din;
  logic [DATA_W-1:0] r_data;
  logic [CH_W-1:0]   r_data_ch;
  logic              r_valid;
  logic              r_busy;

  logic              w_tick;
  logic              w_run;
  logic [5:0]        w_half_nxt;

  assign w_run      = (r_state != ST_IDLE);
  assign w_half_nxt = r_half + 6'd1;

  adc_sclk_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_run   (w_run),
    .o_tick  (w_tick)
  );

  // Frame sequencer: owns SCLK, CS, DIN, the bit position and the result.
  // The shift register keeps only the low DATA_W bits; the four leading
  // zeros of each frame simply fall off the top.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_half    <= '0;
      r_shift   <= '0;
      r_cur_ch  <= '0;
      r_prev_ch <= '0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b1;
      r_din     <= 1'b0;
      r_data    <= '0;
      r_data_ch <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_state  <= ST_FRAME;
            r_cs_n   <= 1'b0;
            r_busy   <= 1'b1;
            r_cur_ch <= i_channel;
            r_half   <= '0;
          end
        end
        ST_FRAME: begin
          if (w_tick) begin
            r_half <= w_half_nxt;
            if (w_half_nxt == 6'(HALF_EXIT)) begin
              r_state   <= ST_GAP;
              r_cs_n    <= 1'b1;
              r_data    <= r_shift;
              r_data_ch <= r_prev_ch;
              r_prev_ch <= r_cur_ch;
              r_valid   <= 1'b1;
            end else if (w_half_nxt[0]) begin
              // falling edge: r_half is even here, so r_half/2 is the bit index
              r_sclk <= 1'b0;
              r_din  <= addr_bit(r_half[4:1], r_cur_ch);
            end else begin
              r_sclk  <= 1'b1;
              r_shift <= {r_shift[DATA_W-2:0], i_adc_dout};
            end
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            if (w_half_nxt == 6'(HALF_END)) begin
              r_half <= '0;
              if (i_enable) begin
                r_state  <= ST_FRAME;
                r_cs_n   <= 1'b0;
                r_cur_ch <= i_channel;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_half <= w_half_nxt;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_adc_cs_n     = r_cs_n;
  assign o_adc_sclk     = r_sclk;
  assign o_adc_din      = r_din;
  assign o_data         = r_data;
  assign o_data_channel = r_data_ch;
  assign o_data_valid   = r_valid;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_adc128s022_spi_master.sv
// Scoreboard bench: two DUTs (H=16 and H=2), each with an ADC model that
// serves random samples and predicts results; a monitor checks every output.
module tb_adc128s022_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endtask

  // ADC framing: address bits 2..4 carry the channel MSB first.
  function automatic int exp_din(input int k, input logic [2:0] c);
    if (k == 2) return int'(c[2]);
    if (k == 3) return int'(c[1]);
    if (k == 4) return int'(c[0]);
    return 0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int HP = (g == 0) ? 16 : 2;

    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic [2:0]  ch   = 3'd0;
    logic        dout = 1'b0;
    logic        cs_n, sclk, din, valid, busy;
    logic [11:0] data;
    logic [2:0]  dch;

    adc128s022_spi_master #(.HALF_PERIOD(HP)) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_enable       (en),
      .i_channel      (ch),
      .o_adc_cs_n     (cs_n),
      .o_adc_sclk     (sclk),
      .o_adc_din      (din),
      .i_adc_dout     (dout),
      .o_data         (data),
      .o_data_channel (dch),
      .o_data_valid   (valid),
      .o_busy         (busy)
    );

    // channel value as seen by the DUT at each clock edge
    logic [2:0] ch_s = 3'd0;
    always @(posedge clk) ch_s <= ch;

    int          t0 = 0, falls = 0, rises = 0, nframes = 0, nvalid = 0;
    bit          in_frame = 1'b0;
    bit          p_cs = 1'b1, p_sclk = 1'b1, p_din = 1'b0, p_valid = 1'b0;
    bit          p_busy = 1'b0, p_rst = 1'b0;
    logic [11:0] sample = '0;
    logic [15:0] word;
    logic [2:0]  req = '0, prev_addr = '0;
    logic [14:0] q[$];
    logic [14:0] e;

    always @(negedge clk) begin
      if (rst) begin
        if (!p_rst) begin
          chk("rst_cs_n", cs_n, 1);
          chk("rst_sclk", sclk, 1);
          chk("rst_din", din, 0);
          chk("rst_valid", valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_data", data, 0);
          chk("rst_data_channel", dch, 0);
        end
        in_frame  = 1'b0;
        prev_addr = '0;   // ADC power-on address and DUT prev_ch both start at 0
        q.delete();
      end else begin
        if (p_cs && !cs_n) begin
          chk("busy_with_cs_fall", busy, 1);
          if (p_busy) chk("frame_period", cyc - t0, 35 * HP);
          t0 = cyc; in_frame = 1'b1; falls = 0; rises = 0; req = ch_s;
          nframes++;
          sample = (g == 0 && nframes == 1) ? 12'hA5C : 12'($urandom);
        end
        if (p_sclk && !sclk) begin
          chk("sclk_fall_time", cyc - t0, (2 * falls + 1) * HP);
          chk("din_bit", din, exp_din(falls, req));
          word = {4'h0, sample};
          if (falls < 16) dout = word[15 - falls];
          falls++;
        end else if (busy) begin
          chk("din_only_on_fall", int'(din != p_din), 0);
        end
        if (!p_sclk && sclk) begin
          chk("sclk_rise_time", cyc - t0, (2 * rises + 2) * HP);
          rises++;
        end
        if (!p_cs && cs_n) begin
          chk("cs_rise_time", cyc - t0, 33 * HP);
          chk("bits_clocked", rises, 16);
          chk("valid_with_cs_rise", valid, 1);
          if (in_frame) begin
            q.push_back({prev_addr, sample});
            prev_addr = req;
          end
          in_frame = 1'b0;
        end
        if (valid) begin
          nvalid++;
          chk("valid_width", int'(p_valid), 0);
          chk("valid_time", cyc - t0, 33 * HP);
          chk("valid_expected", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("data", data, e[11:0]);
            chk("data_channel", dch, e[14:12]);
          end
        end
        if (p_busy && !busy) begin
          chk("busy_fall_time", cyc - t0, 35 * HP);
          chk("idle_cs_n", cs_n, 1);
        end
        if (!busy) chk("idle_lines", int'({cs_n, sclk}), 3);
      end
      p_cs = cs_n; p_sclk = sclk; p_din = din; p_valid = valid;
      p_busy = busy; p_rst = rst;
    end
  end

  int nv, nf;

  initial begin
    repeat (3) @(posedge clk);
    #1 u[0].rst = 1'b0; u[1].rst = 1'b0;

    // idle with enable low
    repeat (100) @(posedge clk);
    #1;
    chk("idle_no_frames", u[0].nframes, 0);
    chk("idle_busy", u[0].busy, 0);
    chk("idle_data", u[0].data, 0);

    // continuous conversion on channel 5; first result is 0xA5C on channel 0
    u[0].ch = 3'd5; u[0].en = 1'b1;
    for (int i = 0; i < 4000 && u[0].nvalid < 3; i++) @(posedge clk);
    chk("run_timeout", int'(u[0].nvalid >= 3), 1);

    // drop enable once bit 7 has been presented
    for (int i = 0; i < 2000 && !(u[0].in_frame && u[0].falls >= 8); i++) @(posedge clk);
    #1;
    chk("bit7_timeout", int'(u[0].falls >= 8), 1);
    nv = u[0].nvalid; nf = u[0].nframes;
    u[0].en = 1'b0;
    repeat (40 * 16) @(posedge clk);
    #1;
    chk("drop_en_valid", u[0].nvalid, nv + 1);
    chk("drop_en_no_new_frame", u[0].nframes, nf);
    chk("drop_en_busy", u[0].busy, 0);

    // reset at bit 10, channel wiggled mid-frame afterwards
    u[0].ch = 3'($urandom); u[0].en = 1'b1;
    for (int i = 0; i < 2000 && !(u[0].in_frame && u[0].falls >= 11); i++) @(posedge clk);
    #1;
    chk("bit10_timeout", int'(u[0].falls >= 11), 1);
    nv = u[0].nvalid;
    u[0].rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_no_valid", u[0].nvalid, nv);
    u[0].rst = 1'b0;
    for (int i = 0; i < 4000 && u[0].nvalid < nv + 3; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 49) == 0) u[0].ch = 3'($urandom);
    end
    chk("post_reset_timeout", int'(u[0].nvalid >= nv + 3), 1);
    u[0].en = 1'b0;
    repeat (40 * 16) @(posedge clk);

    // fast SCLK, channel changing every cycle
    u[1].en = 1'b1;
    for (int i = 0; i < 3000 && u[1].nvalid < 12; i++) begin
      @(posedge clk);
      #1;
      u[1].ch = 3'($urandom);
    end
    chk("fast_timeout", int'(u[1].nvalid >= 12), 1);
    u[1].en = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("fast_idle_busy", u[1].busy, 0);
    chk("scoreboard_drained", u[0].q.size() + u[1].q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
